// File: rtl/fetch_pc_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Presents one fetched word at a time to decode; handles redirects, misaligned traps and halt.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic        halted_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;
  logic        take_halt;
  logic        take_redirect;
  logic [31:0] redirect_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    instr_valid_d   = instr_valid_q;
    misalign_d      = 1'b0;
    // Halt only counts once decode actually takes the instruction; it beats a redirect.
    take_halt       = instr_valid_q && !stall_i && halt_i;
    take_redirect   = redirect_valid_i && (state_q != S_HALTED) && !take_halt;
    redirect_target = (redirect_pc_i[1:0] == 2'b00) ? redirect_pc_i : TRAP_VECTOR;

    if (take_halt) begin
      state_d       = S_HALTED;
      instr_valid_d = 1'b0;
    end else if (take_redirect) begin
      pc_d          = redirect_target;
      misalign_d    = |redirect_pc_i[1:0];
      instr_valid_d = 1'b0;
      case (state_q)
        S_IDLE, S_HOLD: state_d = S_REQ;
        S_REQ:          state_d = imem_gnt_i ? S_DRAIN : S_REQ;
        // A response landing in the same cycle as the redirect is simply dropped,
        // so nothing remains outstanding and fetch can restart immediately.
        S_WAIT, S_DRAIN: state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
        default:        state_d = state_q;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_gnt_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            instr_d       = imem_rdata_i;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) state_d = S_REQ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign halted_o      = (state_q == S_HALTED);
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed walk through the main scenarios, then randomized
// traffic checked against a transaction-level model (pending fetch, presented word, PC).
module tb_fetch_pc_sequencer;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        halt_i = 1'b0;
  logic [31:0] pc_o;
  logic        halted_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference state
  bit          m_bubble;
  bit          m_halted;
  bit          m_pend;
  bit          m_keep;
  bit          m_valid;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  always #5 clk = ~clk;

  fetch_pc_sequencer #(
    .RESET_VECTOR(RESET_VECTOR),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .stall_i         (stall_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .halt_i          (halt_i),
    .pc_o            (pc_o),
    .halted_o        (halted_o),
    .misalign_o      (misalign_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    imem_gnt_i       = 1'b0;
    imem_rvalid_i    = 1'b0;
    imem_rdata_i     = 32'h0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    halt_i           = 1'b0;
  endtask

  // Called at a negedge; asserts reset away from any clock edge and checks it takes effect at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check("rst_pc", pc_o, RESET_VECTOR);
    check("rst_addr", imem_addr_o, RESET_VECTOR);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_ipc", instr_pc_o, 32'h0);
    check("rst_halted", 32'(halted_o), 32'd0);
    check("rst_mis", 32'(misalign_o), 32'd0);
    m_bubble = 1'b1;
    m_halted = 1'b0;
    m_pend   = 1'b0;
    m_keep   = 1'b0;
    m_valid  = 1'b0;
    m_mis    = 1'b0;
    m_pc     = RESET_VECTOR;
    m_instr  = 32'h0;
    m_ipc    = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: compare outputs against the model, apply inputs, advance the model.
  task automatic cycle(input bit gnt, input bit rv, input logic [31:0] rd, input bit st,
                       input bit rdr, input logic [31:0] rpc, input bit hlt);
    bit exp_req;
    bit granted;
    bit resp;
    bit consume;
    exp_req = !m_halted && !m_bubble && !m_pend && !m_valid;
    check("req", 32'(imem_req_o), 32'(exp_req));
    check("pc", pc_o, m_pc);
    check("addr", imem_addr_o, m_pc);
    check("valid", 32'(instr_valid_o), 32'(m_valid));
    if (m_valid) begin
      check("instr", instr_o, m_instr);
      check("instr_pc", instr_pc_o, m_ipc);
    end
    check("halted", 32'(halted_o), 32'(m_halted));
    check("misalign", 32'(misalign_o), 32'(m_mis));

    imem_gnt_i       = gnt;
    imem_rvalid_i    = rv;
    imem_rdata_i     = rd;
    stall_i          = st;
    redirect_valid_i = rdr;
    redirect_pc_i    = rpc;
    halt_i           = hlt;

    granted = exp_req && gnt;
    resp    = m_pend && rv;
    consume = m_valid && !st;
    m_mis   = 1'b0;
    if (consume && hlt) begin
      $display("halt    pc=%08h instr=%08h", m_ipc, m_instr);
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (rdr) begin
      $display("redir   target=%08h", rpc);
      m_bubble = 1'b0;
      m_valid  = 1'b0;
      m_mis    = (rpc[1:0] != 2'b00);
      m_pc     = m_mis ? TRAP_VECTOR : rpc;
      if (resp) m_pend = 1'b0;
      else if (m_pend) m_keep = 1'b0;
      if (granted) begin
        m_pend = 1'b1;
        m_keep = 1'b0;
      end
    end else begin
      m_bubble = 1'b0;
      if (consume) begin
        $display("consume pc=%08h instr=%08h", m_ipc, m_instr);
        m_valid = 1'b0;
      end
      if (resp) begin
        m_pend = 1'b0;
        if (m_keep) begin
          m_valid = 1'b1;
          m_instr = rd;
          m_ipc   = m_pc;
          m_pc    = m_pc + 32'd4;
        end
      end
      if (granted) begin
        m_pend = 1'b1;
        m_keep = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic random_cycle();
    bit          gnt, rv, st, rdr, hlt;
    logic [31:0] rpc;
    int          sel;
    gnt = ($urandom_range(0, 1) == 1);
    rv  = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
    st  = ($urandom_range(0, 9) < 3);
    rdr = ($urandom_range(0, 11) == 0);
    hlt = ($urandom_range(0, 39) == 0);
    sel = $urandom_range(0, 3);
    rpc = $urandom;
    case (sel)
      0: rpc[1:0] = 2'b00;
      1: rpc[1:0] = 2'($urandom_range(1, 3));
      2: rpc = 32'hFFFF_FFFC;
      default: rpc = 32'hFFFF_FFF8;
    endcase
    cycle(gnt, rv, $urandom, st, rdr, rpc, hlt);
  endtask

  initial begin
    int guard;
    @(negedge clk);
    do_reset();

    // First fetch at minimum latency
    idle_cycle();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 1'b0);
    check("first_instr", instr_o, 32'h0050_0093);
    check("first_ipc", instr_pc_o, 32'h0);
    check("first_valid", 32'(instr_valid_o), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("second_addr", imem_addr_o, 32'h4);
    check("second_req", 32'(imem_req_o), 32'd1);

    // Grant withheld, then a stalled hold
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_ipc", instr_pc_o, 32'h4);

    // Misaligned redirect out of HOLD
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
    check("trap_pc", pc_o, TRAP_VECTOR);
    check("trap_mis", 32'(misalign_o), 32'd1);

    // Redirect to the top word while granted -> drain, then wrap after the fetch
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_pc", pc_o, 32'h0);
    check("wrap_ipc", instr_pc_o, 32'hFFFF_FFFC);
    check("wrap_instr", instr_o, 32'h0000_0073);

    // Halt on consume, then nothing more is requested
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
    check("halt_flag", 32'(halted_o), 32'd1);

    // Redirect to 0x100 while waiting, then reset mid-WAIT
    do_reset();
    idle_cycle();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    check("redir_ipc", instr_pc_o, 32'h0000_0100);
    check("redir_instr", instr_o, 32'h0000_0013);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wait_pc", pc_o, 32'h0000_0104);
    do_reset();

    // Randomized epochs; each ends with a reset from whatever state was reached
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 400; i++) random_cycle();
      guard = 0;
      while (!(m_pend && m_keep) && !m_halted && guard < 50) begin
        random_cycle();
        guard++;
      end
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the RV32 core. It issues one outstanding request at a time to instruction memory, increments the PC by 4 on each returned word, and presents the instruction to decode with a hold/stall interface. It also applies branch/jump redirects, kills in-flight fetches, traps misaligned targets and halts on request.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
TRAP_VECTOR, 32'h0000_0080, PC loaded on misaligned redirect target

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (word aligned)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  32  response instruction word
instr_valid_o  out  1  instruction presented to decode
instr_o  out  32  presented instruction
instr_pc_o  out  32  PC of presented instruction
stall_i  in  1  decode cannot consume this cycle
redirect_valid_i  in  1  branch/jump taken
redirect_pc_i  in  32  redirect target
halt_i  in  1  presented instruction is a halt (ecall/ebreak)
pc_o  out  32  current fetch PC
halted_o  out  1  sequencer halted
misalign_o  out  1  one-cycle pulse: misaligned redirect trapped

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: pc = RESET_VECTOR and state = IDLE. imem_req_o, instr_valid_o, halted_o and misalign_o are 0. instr_o and instr_pc_o are 0. imem_addr_o = pc_o = RESET_VECTOR.
- imem_addr_o always equals pc_o.
- States:
  - IDLE: one bubble cycle after reset release, then go to REQ.
  - REQ: imem_req_o = 1.
    - imem_gnt_i = 1: go to WAIT.
    - Otherwise stay in REQ. Address and request stay stable.
  - WAIT: imem_req_o = 0.
    - imem_rvalid_i = 1: instr_o <= imem_rdata_i, instr_pc_o <= pc, instr_valid_o <= 1, pc <= pc+4, go to HOLD.
  - HOLD: instr_valid_o = 1. instr_o and instr_pc_o are stable.
    - stall_i = 0: instruction consumed; instr_valid_o <= 0, go to REQ.
    - stall_i = 1: stay in HOLD.
  - DRAIN: a request was granted but its response must be discarded.
    - imem_rvalid_i = 1: drop the data, go to REQ.
  - HALTED: no requests, instr_valid_o = 0, halted_o = 1. Exit only by reset.
- Minimum latency: gnt in the REQ cycle and rvalid in the first WAIT cycle give instr_valid_o in the next cycle. Throughput is 1 instruction per 3 cycles when stall_i = 0.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Redirect (redirect_valid_i = 1, any state except HALTED):
  - Target selection: pc <= redirect_pc_i if redirect_pc_i[1:0] == 0. Otherwise pc <= TRAP_VECTOR and misalign_o = 1 for the next cycle only.
  - instr_valid_o <= 0. A presented instruction is squashed.
  - Next state by current state:
    - IDLE, HOLD: go to REQ.
    - REQ with gnt same cycle: go to DRAIN.
    - REQ without gnt: go to REQ. The address changes to the target. This is the only permitted address change while req is high.
    - WAIT with rvalid same cycle: data dropped, go to REQ.
    - WAIT without rvalid: go to DRAIN.
    - DRAIN: stay in DRAIN (the pending response is still dropped).
  - A redirect overrides stall_i.
- Halt: sampled only when instr_valid_o = 1 and stall_i = 0. Then go to HALTED. halt_i has priority over a same-cycle redirect. halt_i is ignored otherwise.
- imem_rvalid_i in IDLE, REQ or HOLD is a protocol error and is ignored.
- Reset asserted mid-operation (any state, including DRAIN): immediate return to reset values. Any memory response arriving after reset release is not expected; the memory is reset by the same rst_n.

Test Plan:
- Reset, gnt in the REQ cycle, rvalid 1 cycle later with rdata 32'h0050_0093, stall 0 -> instr_valid_o with instr_o = 32'h0050_0093 and instr_pc_o = 0. Following requests go to 0x4, then 0x8, with 3-cycle spacing.
- gnt withheld 3 cycles at pc 0x4 -> imem_req_o = 1 and imem_addr_o = 0x4 held for all 4 cycles. A single WAIT follows.
- stall_i = 1 for 5 cycles in HOLD at pc 0x8 -> instr_o and instr_pc_o = 0x8 stable, instr_valid_o = 1, no new request. Release -> next request at 0xC.
- redirect to 0x100 while in WAIT for 0xC, rvalid 2 cycles later -> DRAIN, old word never presented. Next request at 0x100, instr_pc_o = 0x100.
- redirect to 0x102 -> misalign_o high exactly 1 cycle. Next request at 0x80.
- redirect to 0xFFFF_FFFC -> fetch completes, next request at 0x0.
- halt_i with a consumed instruction -> halted_o = 1, no further requests.
- rst_n low mid-WAIT -> pc_o = RESET_VECTOR immediately.
